hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage CPU. It generates write-enable, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard sources: load-use data hazards, taken branches resolved in ID, and multi-cycle data-memory accesses that use a req/ack handshake. It also provides a stall performance counter and a sticky memory-timeout error.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the CPU pipeline datapath and the hazard sequencer.
// The slave side is the sequencer; the master side drives the hazard sources.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs_i;
    logic [4:0]       ID_rt_i;
    logic             ID_use_rt_i;
    logic             EX_MemRead_i;
    logic [4:0]       EX_rt_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             pc_we_o;
    logic             ifid_we_o;
    logic             ifid_flush_o;
    logic             idex_we_o;
    logic             idex_flush_o;
    logic             exmem_we_o;
    logic             memwb_bubble_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             error_o;

    modport slave (
        input  ID_rs_i, ID_rt_i, ID_use_rt_i, EX_MemRead_i, EX_rt_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        output pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_flush_o,
               exmem_we_o, memwb_bubble_o, stall_cnt_o, error_o
    );

    modport master (
        output ID_rs_i, ID_rt_i, ID_use_rt_i, EX_MemRead_i, EX_rt_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        input  pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_flush_o,
               exmem_we_o, memwb_bubble_o, stall_cnt_o, error_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: resolves memory-wait, load-use and
// taken-branch hazards, counts stall cycles and flags memory timeouts.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_wcnt;
    logic [15:0]      w_wcnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_error;

    logic w_mem_wait;
    logic w_load_use;
    logic w_pc_we;
    logic w_ifid_we;
    logic w_ifid_flush;
    logic w_idex_we;
    logic w_idex_flush;
    logic w_exmem_we;
    logic w_memwb_bubble;

    assign w_mem_wait = bus.dmem_req_i & ~bus.dmem_ack_i;
    assign w_load_use = bus.EX_MemRead_i && (bus.EX_rt_i != 5'd0) &&
                        ((bus.EX_rt_i == bus.ID_rs_i) ||
                         (bus.ID_use_rt_i && (bus.EX_rt_i == bus.ID_rt_i)));

    always_comb begin
        w_pc_we        = 1'b1;
        w_ifid_we      = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_we      = 1'b1;
        w_idex_flush   = 1'b0;
        w_exmem_we     = 1'b1;
        w_memwb_bubble = 1'b0;
        w_state_nxt    = r_state;
        w_wcnt_nxt     = r_wcnt;

        if (rst_i) begin
            w_pc_we        = 1'b0;
            w_ifid_we      = 1'b0;
            w_idex_we      = 1'b0;
            w_exmem_we     = 1'b0;
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_memwb_bubble = 1'b1;
            w_state_nxt    = S_RUN;
            w_wcnt_nxt     = 16'd0;
        end else if (r_state == S_ERROR || w_mem_wait) begin
            // Freeze every stage and drain a bubble into WB.
            w_pc_we        = 1'b0;
            w_ifid_we      = 1'b0;
            w_idex_we      = 1'b0;
            w_exmem_we     = 1'b0;
            w_memwb_bubble = 1'b1;
            if (r_state == S_MEM_WAIT && r_wcnt == TIMEOUT_W) begin
                w_state_nxt = S_ERROR;
            end else if (r_state != S_ERROR) begin
                w_state_nxt = S_MEM_WAIT;
                w_wcnt_nxt  = (r_state == S_RUN) ? 16'd1 : r_wcnt + 16'd1;
            end
        end else begin
            w_state_nxt = S_RUN;
            w_wcnt_nxt  = 16'd0;
            if (w_load_use) begin
                // A coincident branch is not flushed; it re-resolves next cycle.
                w_pc_we      = 1'b0;
                w_ifid_we    = 1'b0;
                w_idex_flush = 1'b1;
            end else if (bus.branch_taken_i) begin
                w_ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_RUN;
            r_wcnt      <= 16'd0;
            r_stall_cnt <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (!w_pc_we && r_stall_cnt != {CNT_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_state_nxt == S_ERROR) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.pc_we_o        = w_pc_we;
    assign bus.ifid_we_o      = w_ifid_we;
    assign bus.ifid_flush_o   = w_ifid_flush;
    assign bus.idex_we_o      = w_idex_we;
    assign bus.idex_flush_o   = w_idex_flush;
    assign bus.exmem_we_o     = w_exmem_we;
    assign bus.memwb_bubble_o = w_memwb_bubble;
    assign bus.stall_cnt_o    = r_stall_cnt;
    assign bus.error_o        = r_error;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, a saturation/timeout sequence
// and randomized traffic checked against a rule-level reference model.
module tb_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;

    // Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble}
    localparam logic [6:0] O_RUN = 7'b1101010;
    localparam logic [6:0] O_RST = 7'b0010101;
    localparam logic [6:0] O_FRZ = 7'b0000001;
    localparam logic [6:0] O_LU  = 7'b0001110;
    localparam logic [6:0] O_BR  = 7'b1111010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) bus ();
    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic          rst;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic          use_rt;
        logic          memread;
        logic [4:0]    ex_rt;
        logic          br;
        logic          req;
        logic          ack;
        logic [6:0]    exp_o;
        logic [CW-1:0] exp_cnt;
        logic          exp_err;
    } vec_t;

    vec_t tbl[30];

    // Reference model state: mode 0=running, 1=waiting on memory, 2=error.
    int m_mode, m_wait, m_cnt;
    bit m_err;

    function automatic vec_t mk(logic r, int rs, int rt, logic ur, logic mr, int ert,
                                logic br, logic rq, logic ak, logic [6:0] eo,
                                int ec, logic ee);
        vec_t v;
        v.rst = r; v.rs = 5'(rs); v.rt = 5'(rt); v.use_rt = ur; v.memread = mr;
        v.ex_rt = 5'(ert); v.br = br; v.req = rq; v.ack = ak;
        v.exp_o = eo; v.exp_cnt = CW'(ec); v.exp_err = ee;
        return v;
    endfunction

    function automatic logic [6:0] dut_o();
        return {bus.pc_we_o, bus.ifid_we_o, bus.ifid_flush_o, bus.idex_we_o,
                bus.idex_flush_o, bus.exmem_we_o, bus.memwb_bubble_o};
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst;
        bus.ID_rs_i = v.rs; bus.ID_rt_i = v.rt; bus.ID_use_rt_i = v.use_rt;
        bus.EX_MemRead_i = v.memread; bus.EX_rt_i = v.ex_rt;
        bus.branch_taken_i = v.br; bus.dmem_req_i = v.req; bus.dmem_ack_i = v.ack;
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [6:0] model_out(input vec_t v);
        bit lu;
        lu = v.memread && v.ex_rt != 0 &&
             (v.ex_rt == v.rs || (v.use_rt && v.ex_rt == v.rt));
        if (v.rst)                return O_RST;
        if (m_mode == 2)          return O_FRZ;
        if (v.req && !v.ack)      return O_FRZ;
        if (lu)                   return O_LU;
        if (v.br)                 return O_BR;
        return O_RUN;
    endfunction

    task automatic model_step(input vec_t v, input logic [6:0] o);
        if (v.rst) begin
            m_mode = 0; m_wait = 0; m_cnt = 0; m_err = 0;
            return;
        end
        if (!o[6] && m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_mode == 2) return;
        if (v.req && !v.ack) begin
            if (m_mode == 1 && m_wait == TO) begin
                m_mode = 2; m_err = 1;
            end else begin
                m_mode = 1; m_wait = m_wait + 1;
            end
        end else begin
            m_mode = 0; m_wait = 0;
        end
    endtask

    initial begin
        vec_t v;
        logic [6:0] eo;

        tbl[0]  = mk(1, 0,0,0,0,0, 0,0,0, O_RST,  0, 0);
        tbl[1]  = mk(1, 0,0,0,0,0, 0,0,0, O_RST,  0, 0);
        tbl[2]  = mk(0, 0,0,0,0,0, 0,0,0, O_RUN,  0, 0);
        tbl[3]  = mk(0, 5,0,0,1,5, 0,0,0, O_LU,   0, 0);
        tbl[4]  = mk(0, 0,0,0,0,0, 0,0,0, O_RUN,  1, 0);
        tbl[5]  = mk(0, 0,0,0,1,0, 0,0,0, O_RUN,  1, 0);
        tbl[6]  = mk(0, 3,7,0,1,7, 0,0,0, O_RUN,  1, 0);
        tbl[7]  = mk(0, 3,7,1,1,7, 0,0,0, O_LU,   1, 0);
        tbl[8]  = mk(0, 0,0,0,0,0, 1,0,0, O_BR,   2, 0);
        tbl[9]  = mk(0, 5,0,0,1,5, 1,0,0, O_LU,   2, 0);
        tbl[10] = mk(0, 0,0,0,0,0, 1,0,0, O_BR,   3, 0);
        tbl[11] = mk(0, 0,0,0,0,0, 0,1,0, O_FRZ,  3, 0);
        tbl[12] = mk(0, 5,0,0,1,5, 0,1,0, O_FRZ,  4, 0);
        tbl[13] = mk(0, 0,0,0,0,0, 0,1,0, O_FRZ,  5, 0);
        tbl[14] = mk(0, 0,0,0,0,0, 0,1,1, O_RUN,  6, 0);
        tbl[15] = mk(0, 0,0,0,0,0, 0,1,1, O_RUN,  6, 0);
        tbl[16] = mk(0, 0,0,0,0,0, 0,0,0, O_RUN,  6, 0);
        tbl[17] = mk(0, 9,0,0,1,9, 0,1,1, O_LU,   6, 0);
        tbl[18] = mk(0, 0,0,0,0,0, 0,1,0, O_FRZ,  7, 0);
        tbl[19] = mk(0, 0,0,0,0,0, 0,1,0, O_FRZ,  8, 0);
        tbl[20] = mk(0, 0,0,0,0,0, 0,1,0, O_FRZ,  9, 0);
        tbl[21] = mk(0, 0,0,0,0,0, 0,1,0, O_FRZ, 10, 0);
        tbl[22] = mk(0, 0,0,0,0,0, 0,1,0, O_FRZ, 11, 0);
        tbl[23] = mk(0, 0,0,0,0,0, 0,1,1, O_FRZ, 12, 1);
        tbl[24] = mk(0, 0,0,0,0,0, 1,0,0, O_FRZ, 13, 1);
        tbl[25] = mk(0, 0,0,0,0,0, 0,0,0, O_FRZ, 14, 1);
        tbl[26] = mk(0, 0,0,0,0,0, 0,0,0, O_FRZ, 15, 1);
        tbl[27] = mk(0, 0,0,0,0,0, 0,0,0, O_FRZ, 15, 1);
        tbl[28] = mk(1, 0,0,0,0,0, 0,0,0, O_RST, 15, 1);
        tbl[29] = mk(0, 0,0,0,0,0, 0,0,0, O_RUN,  0, 0);

        v = mk(1, 0,0,0,0,0, 0,0,0, O_RST, 0, 0);
        drive(v);
        @(posedge clk);

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check("tbl_ctrl", i, int'(dut_o()), int'(tbl[i].exp_o));
            check("tbl_stall_cnt", i, int'(bus.stall_cnt_o), int'(tbl[i].exp_cnt));
            check("tbl_error", i, int'(bus.error_o), int'(tbl[i].exp_err));
        end

        // Long memory wait: timeout, then counter saturation while frozen.
        @(negedge clk);
        drive(mk(1, 0,0,0,0,0, 0,0,0, O_RST, 0, 0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(mk(0, 0,0,0,0,0, 0,1,0, O_FRZ, 0, 0));
            #1;
            check("sat_ctrl", i, int'(dut_o()), int'(O_FRZ));
            if (i == 5) check("timeout_err_set", i, int'(bus.error_o), 1);
        end
        @(negedge clk);
        drive(mk(0, 0,0,0,0,0, 0,1,1, O_FRZ, 0, 0));
        #1;
        check("sat_cnt", 20, int'(bus.stall_cnt_o), 15);
        check("late_ack_ignored", 20, int'(dut_o()), int'(O_FRZ));
        check("err_sticky", 20, int'(bus.error_o), 1);

        // Randomized traffic against the reference model.
        @(negedge clk);
        v = mk(1, 0,0,0,0,0, 0,0,0, O_RST, 0, 0);
        drive(v);
        model_step(v, O_RST);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            v.rst     = ($urandom_range(0, 99) < 2);
            v.rs      = 5'($urandom_range(0, 3));
            v.rt      = 5'($urandom_range(0, 3));
            v.use_rt  = 1'($urandom_range(0, 1));
            v.memread = 1'($urandom_range(0, 1));
            v.ex_rt   = 5'($urandom_range(0, 3));
            v.br      = ($urandom_range(0, 99) < 30);
            v.req     = ($urandom_range(0, 99) < 40);
            v.ack     = ($urandom_range(0, 99) < 35);
            drive(v);
            #1;
            eo = model_out(v);
            check("rnd_ctrl", i, int'(dut_o()), int'(eo));
            check("rnd_stall_cnt", i, int'(bus.stall_cnt_o), m_cnt);
            check("rnd_error", i, int'(bus.error_o), int'(m_err));
            model_step(v, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
